// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and defaults for the UART receive buffer.
package uart_pkg;

  localparam int UART_RX_DATA_WIDTH      = 8;
  localparam int UART_RX_DEFAULT_TIMEOUT = 640;

  typedef struct packed {
    logic                          parity_err;
    logic [UART_RX_DATA_WIDTH-1:0] data;
  } rx_entry_t;

  typedef enum logic [1:0] {
    RX_TO_IDLE     = 2'd0,
    RX_TO_COUNTING = 2'd1,
    RX_TO_EXPIRED  = 2'd2
  } rx_to_state_t;

endpackage

// File: rtl/uart_rx_timeout.sv
// rtl/uart_rx_timeout.sv - character-timeout timer, used when UART_RX_FIFO_TIMEOUT_EN is defined.
module uart_rx_timeout
  import uart_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = UART_RX_DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  logic empty_next,
  output logic timeout
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  rx_to_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RX_TO_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Decisions use next-cycle emptiness so the timer starts on the edge rd_valid rises.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush || empty_next) begin
      state_d = RX_TO_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        RX_TO_IDLE: begin
          state_d = RX_TO_COUNTING;
          cnt_d   = '0;
        end
        RX_TO_COUNTING: begin
          if (push || pop) begin
            cnt_d = '0;
          end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            state_d = RX_TO_EXPIRED;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RX_TO_EXPIRED: begin
          if (push || pop) begin
            state_d = RX_TO_COUNTING;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = RX_TO_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    timeout = (state_q == RX_TO_EXPIRED);
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - FWFT receive FIFO with overrun flag; UART_RX_FIFO_TIMEOUT_EN adds character timeout.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
`ifdef UART_RX_FIFO_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = UART_RX_DEFAULT_TIMEOUT
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_valid,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    wr_parity_err,
  input  logic                    rd_ready,
  output logic                    rd_valid,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_parity_err,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    full,
  output logic                    empty,
  output logic                    overrun,
  input  logic                    overrun_clr,
  input  logic                    flush
`ifdef UART_RX_FIFO_TIMEOUT_EN
  , output logic                  timeout
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Entry layout matches rx_entry_t: {parity_err, data}.
  logic [DATA_WIDTH:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] level_q, level_d;
  logic          overrun_q, overrun_d;
  logic          push, pop, drop;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    rd_valid = !empty;
    pop      = rd_valid && rd_ready;
    push     = wr_valid && (!full || pop);
    drop     = wr_valid && full && !pop && !flush;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
    level_d = wr_ptr_d - rd_ptr_d;
    // A drop in the same cycle as a clear keeps the flag set.
    overrun_d = overrun_q;
    if (drop) begin
      overrun_d = 1'b1;
    end else if (overrun_clr || flush) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {wr_parity_err, wr_data};
    end
  end

  always_comb begin
    rd_data       = '0;
    rd_parity_err = 1'b0;
    if (!empty) begin
      {rd_parity_err, rd_data} = mem_q[rd_ptr_q[AW-1:0]];
    end
    level   = level_q;
    overrun = overrun_q;
  end

`ifdef UART_RX_FIFO_TIMEOUT_EN
  uart_rx_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk        (clk),
    .reset      (reset),
    .push       (push && !flush),
    .pop        (pop && !flush),
    .flush      (flush),
    .empty_next (wr_ptr_d == rd_ptr_d),
    .timeout    (timeout)
  );
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_parity_err;
  logic       rd_ready;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_parity_err;
  logic [4:0] level;
  logic       full;
  logic       empty;
  logic       overrun;
  logic       overrun_clr;
  logic       flush;
`ifdef UART_RX_FIFO_TIMEOUT_EN
  logic       timeout;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

`ifdef UART_RX_FIFO_TIMEOUT_EN
  uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(16), .TIMEOUT_CYCLES(20)) u_dut (
`else
  uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(16)) u_dut (
`endif
    .clk           (clk),
    .reset         (reset),
    .wr_valid      (wr_valid),
    .wr_data       (wr_data),
    .wr_parity_err (wr_parity_err),
    .rd_ready      (rd_ready),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .rd_parity_err (rd_parity_err),
    .level         (level),
    .full          (full),
    .empty         (empty),
    .overrun       (overrun),
    .overrun_clr   (overrun_clr),
    .flush         (flush)
`ifdef UART_RX_FIFO_TIMEOUT_EN
    , .timeout     (timeout)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    wr_valid      = 1'b0;
    wr_data       = 8'h00;
    wr_parity_err = 1'b0;
    rd_ready      = 1'b0;
    overrun_clr   = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic push(input logic [7:0] d, input logic p);
    wr_valid      = 1'b1;
    wr_data       = d;
    wr_parity_err = p;
    step();
    idle();
  endtask

  task automatic pop_check(input string tag, input logic [7:0] d, input logic p);
    check({tag, "_data"}, 32'(rd_data), 32'(d));
    check({tag, "_perr"}, 32'(rd_parity_err), 32'(p));
    rd_ready = 1'b1;
    step();
    idle();
  endtask

  initial begin
    logic [7:0] q[$];
    int pushed, popped, cyc;
    bit dp, dq;

    idle();
    reset = 1'b0;
    step();
    step();
    check("rst_level", 32'(level), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    reset = 1'b1;
    step();

    // Test 1: two frames, FWFT ordering, no same-cycle pass-through
    wr_valid = 1'b1; wr_data = 8'h5A; wr_parity_err = 1'b0;
    #1;
    check("t1_no_passthru", 32'(rd_valid), 32'd0);
    step();
    idle();
    check("t1_latency", 32'(rd_valid), 32'd1);
    push(8'hC3, 1'b1);
    check("t1_level", 32'(level), 32'd2);
    pop_check("t1_head0", 8'h5A, 1'b0);
    pop_check("t1_head1", 8'hC3, 1'b1);
    check("t1_empty", 32'(empty), 32'd1);

    // Test 2: fill, overrun drop, drain, clear
    for (int i = 0; i < 16; i++) push(8'(i), 1'b0);
    check("t2_full", 32'(full), 32'd1);
    check("t2_level", 32'(level), 32'd16);
    check("t2_overrun_pre", 32'(overrun), 32'd0);
    push(8'hFF, 1'b0);
    check("t2_overrun", 32'(overrun), 32'd1);
    check("t2_level_drop", 32'(level), 32'd16);
    for (int i = 0; i < 16; i++) pop_check($sformatf("t2_rd%0d", i), 8'(i), 1'b0);
    check("t2_empty", 32'(empty), 32'd1);
    check("t2_overrun_sticky", 32'(overrun), 32'd1);
    overrun_clr = 1'b1;
    step();
    idle();
    check("t2_overrun_clr", 32'(overrun), 32'd0);

    // Test 3: push and pop in the same cycle while full
    for (int i = 0; i < 16; i++) push(8'(i), 1'b0);
    check("t3_full", 32'(full), 32'd1);
    check("t3_head", 32'(rd_data), 32'h00);
    wr_valid = 1'b1; wr_data = 8'hAA; rd_ready = 1'b1;
    step();
    idle();
    check("t3_level", 32'(level), 32'd16);
    check("t3_overrun", 32'(overrun), 32'd0);
    for (int i = 1; i < 16; i++) pop_check($sformatf("t3_rd%0d", i), 8'(i), 1'b0);
    pop_check("t3_rd16", 8'hAA, 1'b0);
    check("t3_empty", 32'(empty), 32'd1);

    // Test 4: interleaved traffic across pointer wrap
    pushed = 0; popped = 0; cyc = 0;
    while ((pushed < 20 || popped < 20) && cyc < 200) begin
      dp = (pushed < 20) && (cyc % 3 != 2);
      dq = (q.size() > 0) && (cyc % 3 != 0);
      if (dq) check($sformatf("t4_rd%0d", popped), 32'(rd_data), 32'(q[0]));
      wr_valid = dp;
      wr_data  = 8'(8'h40 + pushed);
      rd_ready = dq;
      step();
      if (dq) begin
        void'(q.pop_front());
        popped++;
      end
      if (dp) begin
        q.push_back(8'(8'h40 + pushed));
        pushed++;
      end
      check($sformatf("t4_level%0d", cyc), 32'(level), 32'(q.size()));
      cyc++;
    end
    idle();
    check("t4_popped", 32'(popped), 32'd20);
    check("t4_empty", 32'(empty), 32'd1);

    // Test 5: flush wins over a same-cycle push
    for (int i = 0; i < 5; i++) push(8'(8'h80 + i), 1'b1);
    check("t5_level_pre", 32'(level), 32'd5);
    wr_valid = 1'b1; wr_data = 8'h77; flush = 1'b1;
    step();
    idle();
    check("t5_level", 32'(level), 32'd0);
    check("t5_empty", 32'(empty), 32'd1);
    check("t5_rd_valid", 32'(rd_valid), 32'd0);
    step();
    check("t5_discarded", 32'(rd_valid), 32'd0);

`ifdef UART_RX_FIFO_TIMEOUT_EN
    // Test 6: character timeout 20 cycles after rd_valid rises
    check("t6_idle", 32'(timeout), 32'd0);
    push(8'h11, 1'b0);
    check("t6_rd_valid", 32'(rd_valid), 32'd1);
    for (int k = 1; k < 20; k++) begin
      step();
      if (timeout) check($sformatf("t6_early%0d", k), 32'(timeout), 32'd0);
    end
    check("t6_before", 32'(timeout), 32'd0);
    step();
    check("t6_expired", 32'(timeout), 32'd1);
    pop_check("t6_rd", 8'h11, 1'b0);
    check("t6_cleared", 32'(timeout), 32'd0);
    check("t6_empty", 32'(empty), 32'd1);
    for (int k = 0; k < 25; k++) step();
    check("t6_stays_idle", 32'(timeout), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side character buffer sitting directly downstream of the UART receiver. It captures each received frame (data plus parity-error flag) on the receiver's single-cycle valid pulse. It presents frames in order to the host through a first-word-fall-through valid/ready interface. It also reports fill level and sticky overrun, and optionally raises a character-timeout indication.

Parameters:
- DATA_WIDTH, 8, width of received data word; must match receiver Data_Width.
- DEPTH, 16, number of entries; power of two, >= 2.
- TIMEOUT_CYCLES, 640, clk cycles of write inactivity before timeout (4 chars x 10 bits x 16 oversample); used only with UART_RX_FIFO_TIMEOUT_EN.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- wr_valid  input  1  receiver frame-done pulse (rx_valid).
- wr_data  input  DATA_WIDTH  received data word.
- wr_parity_err  input  1  parity error for the frame.
- rd_ready  input  1  host accepts head entry.
- rd_valid  output  1  head entry available.
- rd_data  output  DATA_WIDTH  head entry data.
- rd_parity_err  output  1  head entry parity flag.
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  output  1  level == DEPTH.
- empty  output  1  level == 0.
- overrun  output  1  sticky: a frame was dropped.
- overrun_clr  input  1  clears overrun.
- flush  input  1  synchronous discard of all entries.
- timeout  output  1  character timeout; present only with UART_RX_FIFO_TIMEOUT_EN.

Behaviour:
- Reset (reset=0, async): pointers 0, level 0, empty 1, full 0, rd_valid 0, overrun 0, timeout 0. Storage contents are not reset.
- Storage: DEPTH x (DATA_WIDTH+1) registers. Write/read pointers are $clog2(DEPTH)+1 bits; the extra MSB is the wrap bit. full = MSBs differ and low bits are equal; empty = pointers equal.
- rd_valid = !empty. rd_data/rd_parity_err show the entry at the read pointer combinationally, and are driven 0 when empty.
- Push: wr_valid && (!full || pop). The entry is written at the write pointer, and the pointer increments modulo 2*DEPTH.
- Pop: rd_valid && rd_ready. The read pointer increments.
- Latency: a push in cycle N makes rd_valid=1 in cycle N+1. There is no same-cycle pass-through when empty.
- Simultaneous push and pop:
  - Not full: both occur, level unchanged.
  - Full: pop frees the slot, push accepted, level stays DEPTH, no overrun.
- Push when full without pop: frame dropped, pointers unchanged, overrun set next cycle.
- overrun is cleared by overrun_clr or flush. If set and clear occur in the same cycle, set wins.
- flush: highest priority; pointers equalise to 0 next cycle, and any same-cycle push or pop is ignored.
- rd_ready while empty: no effect.
- level is the registered difference of the pointers.

Optional Feature:
Macro UART_RX_FIFO_TIMEOUT_EN.
- Defined: the timeout port exists, and a timer FSM is instantiated with states IDLE, COUNTING, EXPIRED.
  - IDLE -> COUNTING when the FIFO becomes non-empty; the counter loads 0.
  - In COUNTING, the counter increments each cycle and restarts at 0 on any push or pop.
  - COUNTING -> EXPIRED when the counter reaches TIMEOUT_CYCLES-1. timeout=1 while in EXPIRED.
  - EXPIRED -> COUNTING (counter 0) on push or pop when the FIFO remains non-empty.
  - Any state -> IDLE when empty or on flush.
- Undefined: no timeout port, no timer logic.

Decomposition:
- Package uart_pkg holds:
  - rx_entry_t: packed struct {parity_err, data[DATA_WIDTH-1:0]}.
  - rx_to_state_t: timer enum IDLE/COUNTING/EXPIRED.
  - UART_RX_DEFAULT_TIMEOUT = 640.
- One sub-module, uart_rx_timeout, holds the timer FSM and counter. It is instantiated only under UART_RX_FIFO_TIMEOUT_EN.

Test Plan:
1. Reset, then push 0x5A (perr=0) and 0xC3 (perr=1) with rd_ready=0 -> level=2. Head is 0x5A/0; after one pop, head is 0xC3/1, then empty=1.
2. Push 16 frames 0x00..0x0F -> full=1, level=16. Push 0xFF -> overrun=1 and 0xFF absent; reads return 0x00..0x0F in order. overrun_clr -> overrun=0.
3. Fill to 16, then push 0xAA with rd_ready=1 in the same cycle -> 0x00 popped, level stays 16, overrun=0, and 0xAA is the 16th read.
4. Push 20 and pop 20 interleaved, covering pointer wrap -> data order preserved, level never exceeds 16, empty=1 at end.
5. Load 5 entries, assert flush with wr_valid=1 in the same cycle -> next cycle level=0, empty=1, rd_valid=0; the pushed word is discarded.
6. With UART_RX_FIFO_TIMEOUT_EN and TIMEOUT_CYCLES=20: push one frame and idle -> timeout=1 exactly 20 cycles after rd_valid rises. Pop -> timeout=0 and the FSM returns to IDLE.
